// File: rtl/cp0_intc.sv
// CP0 at the M stage: SR/Cause/EPC/PRId/Count/Compare, exception and interrupt entry, eret.
// int_req is combinational in the entry cycle and state updates at the next edge; no flow control, never stalls.
module cp0_intc #(
  parameter int          NUM_HWINT = 6,
  parameter bit          TIMER_EN  = 1'b1,
  parameter logic [31:0] PRID      = 32'h2019_0701,
  parameter logic [31:0] HANDLER   = 32'h0000_4180
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 we,
  input  logic [4:0]           addr,
  input  logic [31:0]          din,
  output logic [31:0]          dout,
  input  logic [31:0]          pc_m,
  input  logic                 bd_m,
  input  logic [4:0]           exc_code,
  input  logic                 eret_m,
  input  logic [NUM_HWINT-1:0] hwint,
  output logic                 int_req,
  output logic [31:0]          handler_pc,
  output logic [31:0]          epc_out,
  output logic                 exl
);

  localparam logic [4:0] A_COUNT   = 5'd9;
  localparam logic [4:0] A_COMPARE = 5'd11;
  localparam logic [4:0] A_SR      = 5'd12;
  localparam logic [4:0] A_CAUSE   = 5'd13;
  localparam logic [4:0] A_EPC     = 5'd14;
  localparam logic [4:0] A_PRID    = 5'd15;

  logic [5:0]  im;
  logic        ie;
  logic        exl_q;
  logic        bd;
  logic [5:0]  ip;
  logic [4:0]  exc_q;
  logic [31:0] epc;
  logic [31:0] count;
  logic [31:0] compare;
  logic        ti;

  logic [5:0]  hw_ext;
  logic [5:0]  ip_live;
  logic [5:0]  ip_next;
  logic        match;
  logic        ti_live;
  logic        ti_next;
  logic        int_irq;
  logic        exc;
  logic        wr;
  logic [31:0] epc_entry;

  // Bit i of the 6-bit vectors is architectural IP[i+2] / Cause bit 10+i.
  assign hw_ext  = 6'(hwint);
  assign match   = TIMER_EN && (count == compare);
  assign ti_live = ti | match;
  assign ip_live = hw_ext | {ti_live, 5'b0};

  // The entry decision uses live lines so a one-cycle hwint pulse is taken in its own cycle.
  assign int_irq = ie & ~exl_q & (|(im & ip_live));
  assign exc     = (exc_code != 5'd0) & ~exl_q;
  assign int_req = int_irq | exc;

  assign wr        = we & ~int_req;
  assign ti_next   = (wr && addr == A_COMPARE) ? 1'b0 : ti_live;
  assign ip_next   = hw_ext | {ti_next, 5'b0};
  assign epc_entry = bd_m ? (pc_m - 32'd4) : pc_m;

  always_ff @(posedge clk) begin
    if (reset) begin
      im      <= '0;
      ie      <= 1'b0;
      exl_q   <= 1'b0;
      bd      <= 1'b0;
      ip      <= '0;
      exc_q   <= '0;
      epc     <= '0;
      count   <= '0;
      compare <= 32'hFFFF_FFFF;
      ti      <= 1'b0;
    end else begin
      ti <= ti_next;
      ip <= ip_next;
      count <= (wr && addr == A_COUNT) ? din : count + 32'd1;
      if (wr && addr == A_COMPARE) compare <= din;
      if (wr && addr == A_EPC) epc <= {din[31:2], 2'b00};
      if (wr && addr == A_SR) begin
        im    <= din[15:10];
        exl_q <= din[1];
        ie    <= din[0];
      end
      // Later assignments win: an eret in the same cycle as an SR write still clears EXL.
      if (int_req) begin
        exl_q <= 1'b1;
        bd    <= bd_m;
        epc   <= {epc_entry[31:2], 2'b00};
        exc_q <= int_irq ? 5'd0 : exc_code;
      end else if (eret_m && exl_q) begin
        exl_q <= 1'b0;
      end
    end
  end

  always_comb begin
    dout = '0;
    case (addr)
      A_COUNT:   dout = TIMER_EN ? count : 32'd0;
      A_COMPARE: dout = TIMER_EN ? compare : 32'd0;
      A_SR:      dout = {16'b0, im, 8'b0, exl_q, ie};
      A_CAUSE:   dout = {bd, 15'b0, ip, 3'b0, exc_q, 2'b0};
      A_EPC:     dout = epc;
      A_PRID:    dout = PRID;
      default:   dout = '0;
    endcase
  end

  assign handler_pc = HANDLER;
  assign epc_out    = epc;
  assign exl        = exl_q;

endmodule
